// File: rtl/traffic_phase_timer_pkg.sv
// rtl/traffic_phase_timer_pkg.sv - shared state encodings, lamp codes and BCD helper
package traffic_phase_timer_pkg;

    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        RED1   = 3'd2,
        SIDE_G = 3'd3,
        SIDE_Y = 3'd4,
        RED2   = 3'd5,
        NIGHT  = 3'd6
    } state_t;

    // Lamp codes are {red,yellow,green}
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    // Any code 4'hA-4'hF leaves a downstream 7-segment digit dark
    localparam logic [3:0] BLANK = 4'hF;

    // Duration in seconds (1..99) to packed {tens,ones} BCD
    function automatic logic [7:0] to_bcd(input int t);
        return {4'(t / 10), 4'(t % 10)};
    endfunction

endpackage

// File: rtl/traffic_phase_timer_tick.sv
// rtl/traffic_phase_timer_tick.sv - one-second tick prescaler
// Ports: clk, rst (sync active-high), tick (one clk wide every CLK_DIV clks)
module tick_gen #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/traffic_phase_timer.sv
// rtl/traffic_phase_timer.sv - two-way intersection lamp sequencer with BCD countdown
// Ports: clk, rst (sync active-high), night (flashing-yellow request, sampled on tick),
//        main_rgy/side_rgy lamps {r,y,g}, tens/ones BCD seconds left (4'hF blank),
//        phase (current state encoding)
module traffic_phase_timer
    import traffic_phase_timer_pkg::*;
#(
    parameter int CLK_DIV  = 50_000_000,
    parameter int T_MAIN_G = 25,
    parameter int T_SIDE_G = 15,
    parameter int T_YEL    = 3,
    parameter int T_ALLRED = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       night,
    output logic [2:0] main_rgy,
    output logic [2:0] side_rgy,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [2:0] phase
);

    localparam logic [7:0] BCD_MAIN_G = to_bcd(T_MAIN_G);
    localparam logic [7:0] BCD_SIDE_G = to_bcd(T_SIDE_G);
    localparam logic [7:0] BCD_YEL    = to_bcd(T_YEL);
    localparam logic [7:0] BCD_ALLRED = to_bcd(T_ALLRED);

    logic       tick;
    state_t     state, state_nx;
    logic [7:0] count, count_nx;
    logic       flash, flash_nx;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    function automatic state_t succ(input state_t s);
        case (s)
            MAIN_G:  return MAIN_Y;
            MAIN_Y:  return RED1;
            RED1:    return SIDE_G;
            SIDE_G:  return SIDE_Y;
            SIDE_Y:  return RED2;
            default: return MAIN_G;
        endcase
    endfunction

    function automatic logic [7:0] load_of(input state_t s);
        case (s)
            MAIN_G:         return BCD_MAIN_G;
            SIDE_G:         return BCD_SIDE_G;
            MAIN_Y, SIDE_Y: return BCD_YEL;
            RED1, RED2:     return BCD_ALLRED;
            default:        return {BLANK, BLANK};
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MAIN_G;
            count <= BCD_MAIN_G;
            flash <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            flash <= flash_nx;
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        flash_nx = flash;
        case (state)
            NIGHT: begin
                if (tick) begin
                    if (night) begin
                        flash_nx = ~flash;
                    end else begin
                        // Leave night through all-red so cross traffic clears first
                        state_nx = RED2;
                        count_nx = BCD_ALLRED;
                        flash_nx = 1'b0;
                    end
                end
            end
            MAIN_G, MAIN_Y, RED1, SIDE_G, SIDE_Y, RED2: begin
                if (tick) begin
                    if (night) begin
                        // Night request takes priority over a phase expiring on the same tick
                        state_nx = NIGHT;
                        count_nx = {BLANK, BLANK};
                        flash_nx = 1'b1;
                    end else if (count == 8'h01) begin
                        state_nx = succ(state);
                        count_nx = load_of(succ(state));
                    end else if (count[3:0] == 4'd0) begin
                        count_nx = {count[7:4] - 4'd1, 4'd9};
                    end else begin
                        count_nx = {count[7:4], count[3:0] - 4'd1};
                    end
                end
            end
            default: begin
                state_nx = MAIN_G;
                count_nx = BCD_MAIN_G;
                flash_nx = 1'b0;
            end
        endcase
    end

    always_comb begin
        main_rgy = RED;
        side_rgy = RED;
        case (state)
            MAIN_G:  begin main_rgy = GRN; side_rgy = RED; end
            MAIN_Y:  begin main_rgy = YEL; side_rgy = RED; end
            SIDE_G:  begin main_rgy = RED; side_rgy = GRN; end
            SIDE_Y:  begin main_rgy = RED; side_rgy = YEL; end
            NIGHT:   begin
                main_rgy = flash ? YEL : OFF;
                side_rgy = flash ? YEL : OFF;
            end
            default: begin main_rgy = RED; side_rgy = RED; end
        endcase
        tens  = count[7:4];
        ones  = count[3:0];
        phase = state;
    end

endmodule
